// File: rtl/pipe_step_controller_if.sv
// pipe_step_controller_if: RX FIFO head/pop, pipeline control, dump handshake
// and LED indicators shared between the step controller and its surroundings.
interface pipe_step_controller_if #(
  parameter int PC_WIDTH = 8
);
  logic [7:0]          rxData;
  logic                rxAvailable;
  logic                readFifoFlag;
  logic                endOfProgram;
  logic [PC_WIDTH-1:0] pcFE;
  logic                dumpDone;
  logic                pipeEnable;
  logic                pipeReset;
  logic                dumpStart;
  logic                cmdError;
  logic                ledIdle;
  logic                ledStep;
  logic                ledCont;
  logic                ledSend;

  // Controller side
  modport master (
    input  rxData, rxAvailable, endOfProgram, pcFE, dumpDone,
    output readFifoFlag, pipeEnable, pipeReset, dumpStart, cmdError,
           ledIdle, ledStep, ledCont, ledSend
  );

  // FIFO / datapath / dump-logic side
  modport slave (
    output rxData, rxAvailable, endOfProgram, pcFE, dumpDone,
    input  readFifoFlag, pipeEnable, pipeReset, dumpStart, cmdError,
           ledIdle, ledStep, ledCont, ledSend
  );
endinterface

// File: rtl/pipe_step_controller.sv
// pipe_step_controller: UART debug command sequencer for the 5-stage MIPS
// pipeline. Decodes command bytes from the RX FIFO, drives the global pipeline
// enable / reset, and hands off to the latch-dump logic after every halt.
module pipe_step_controller #(
  parameter int PC_WIDTH        = 8,
  parameter int PIPE_RST_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  pipe_step_controller_if.master bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARG   = 3'd1;
  localparam logic [2:0] ST_STEP  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DUMP  = 3'd4;
  localparam logic [2:0] ST_WAITD = 3'd5;
  localparam logic [2:0] ST_PRST  = 3'd6;

  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_NSTEP = 8'h4E;  // 'N'
  localparam logic [7:0] CMD_CONT  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_HALT  = 8'h48;  // 'H'
  localparam logic [7:0] CMD_BP    = 8'h42;  // 'B'
  localparam logic [7:0] CMD_CLRBP = 8'h58;  // 'X'
  localparam logic [7:0] CMD_RST   = 8'h52;  // 'R'

  logic [2:0]          state, state_nxt;
  logic                arg_is_bp, arg_is_bp_nxt;   // ARG collects a breakpoint (1) or a step count (0)
  logic [PC_WIDTH-1:0] bp, bp_nxt;
  logic                bp_valid, bp_valid_nxt;
  logic                eop_seen, eop_seen_nxt;
  logic [7:0]          step_cnt, step_cnt_nxt;
  logic [3:0]          prst_cnt, prst_cnt_nxt;
  logic                first_run, first_run_nxt;
  logic                rx_ok;                      // pop gate: closed the cycle after a pop and out of reset

  logic                rx_take;
  logic                pop;
  logic                bp_hit;
  logic                halt_cmd;
  logic                pipe_enable;
  logic                pipe_reset;
  logic                dump_start;
  logic                cmd_error;

  assign rx_take = bus.rxAvailable && rx_ok;
  assign bp_hit  = bp_valid && (bus.pcFE == bp) && !first_run;

  // Next-state and output decode for the command sequencer
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_nxt     = state;
    arg_is_bp_nxt = arg_is_bp;
    bp_nxt        = bp;
    bp_valid_nxt  = bp_valid;
    eop_seen_nxt  = eop_seen;
    step_cnt_nxt  = step_cnt;
    prst_cnt_nxt  = prst_cnt;
    first_run_nxt = first_run;
    pop           = 1'b0;
    halt_cmd      = 1'b0;
    pipe_enable   = 1'b0;
    pipe_reset    = 1'b0;
    dump_start    = 1'b0;
    cmd_error     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (rx_take) begin
          pop = 1'b1;
          case (bus.rxData)
            CMD_STEP: begin
              if (eop_seen) cmd_error = 1'b1;
              else begin
                step_cnt_nxt = 8'd1;
                state_nxt    = ST_STEP;
              end
            end
            CMD_NSTEP: begin
              if (eop_seen) cmd_error = 1'b1;
              else begin
                arg_is_bp_nxt = 1'b0;
                state_nxt     = ST_ARG;
              end
            end
            CMD_CONT: begin
              if (eop_seen) cmd_error = 1'b1;
              else begin
                first_run_nxt = 1'b1;
                state_nxt     = ST_RUN;
              end
            end
            CMD_HALT: begin
              // Nothing is running, so a halt is silently accepted.
            end
            CMD_BP: begin
              arg_is_bp_nxt = 1'b1;
              state_nxt     = ST_ARG;
            end
            CMD_CLRBP: bp_valid_nxt = 1'b0;
            CMD_RST: begin
              prst_cnt_nxt = 4'(PIPE_RST_CYCLES);
              state_nxt    = ST_PRST;
            end
            default: cmd_error = 1'b1;
          endcase
        end
      end

      ST_ARG: begin
        if (rx_take) begin
          pop = 1'b1;
          if (arg_is_bp) begin
            bp_nxt       = PC_WIDTH'(bus.rxData);
            bp_valid_nxt = 1'b1;
            state_nxt    = ST_IDLE;
          end else if (bus.rxData == 8'd0) begin
            state_nxt = ST_DUMP;
          end else begin
            step_cnt_nxt = bus.rxData;
            state_nxt    = ST_STEP;
          end
        end
      end

      ST_STEP: begin
        // The current enable cycle always completes, even when EOP arrives.
        pipe_enable  = 1'b1;
        step_cnt_nxt = step_cnt - 8'd1;
        if (bus.endOfProgram) eop_seen_nxt = 1'b1;
        if (step_cnt == 8'd1 || bus.endOfProgram) state_nxt = ST_DUMP;
      end

      ST_RUN: begin
        first_run_nxt = 1'b0;
        if (rx_take) begin
          pop       = 1'b1;
          halt_cmd  = (bus.rxData == CMD_HALT);
          cmd_error = !halt_cmd;
        end
        if (bus.endOfProgram) eop_seen_nxt = 1'b1;
        // Any halt condition suppresses this cycle's enable, so the fetch
        // PC stays parked on the breakpoint address.
        if (bp_hit || bus.endOfProgram || halt_cmd) state_nxt = ST_DUMP;
        else pipe_enable = 1'b1;
      end

      ST_DUMP: begin
        dump_start = 1'b1;
        state_nxt  = ST_WAITD;
      end

      ST_WAITD: begin
        if (bus.dumpDone) state_nxt = ST_IDLE;
      end

      ST_PRST: begin
        pipe_reset   = 1'b1;
        eop_seen_nxt = 1'b0;
        prst_cnt_nxt = prst_cnt - 4'd1;
        if (prst_cnt <= 4'd1) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and command registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      arg_is_bp <= 1'b0;
      bp        <= '0;
      bp_valid  <= 1'b0;
      eop_seen  <= 1'b0;
      step_cnt  <= 8'd0;
      prst_cnt  <= 4'd0;
      first_run <= 1'b0;
      rx_ok     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state     <= state_nxt;
      arg_is_bp <= arg_is_bp_nxt;
      bp        <= bp_nxt;
      bp_valid  <= bp_valid_nxt;
      eop_seen  <= eop_seen_nxt;
      step_cnt  <= step_cnt_nxt;
      prst_cnt  <= prst_cnt_nxt;
      first_run <= first_run_nxt;
      rx_ok     <= !pop;
    end
  end

  assign bus.readFifoFlag = pop;
  assign bus.pipeEnable   = pipe_enable;
  assign bus.pipeReset    = pipe_reset;
  assign bus.dumpStart    = dump_start;
  assign bus.cmdError     = cmd_error;
  assign bus.ledIdle      = (state == ST_IDLE);
  assign bus.ledStep      = (state == ST_STEP);
  assign bus.ledCont      = (state == ST_RUN);
  assign bus.ledSend      = (state == ST_DUMP) || (state == ST_WAITD);

endmodule
